// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Stall/flush sequencer for the 5-stage RV32I pipeline, with a
//               data-memory wait FSM, access timeout and perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
   parameter int DMEM_TIMEOUT = 16,
   parameter int TO_W         = 5,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hz_stall,
   input  logic             ex_redirect,
   input  logic             imem_ready,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   input  logic             wb_halt,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_flush,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             mem_wb_flush,
   output logic             halted,
   output logic             bus_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [1:0]      c_st_run       = 2'd0;
   localparam logic [1:0]      c_st_dmem_wait = 2'd1;
   localparam logic [1:0]      c_st_halted    = 2'd2;
   localparam logic [TO_W-1:0] c_to_last      = TO_W'(DMEM_TIMEOUT - 1);

   logic [1:0]       r_state;
   logic [TO_W-1:0]  r_wait_cnt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             r_bus_err;

   logic [1:0]       w_state_nxt;
   logic [TO_W-1:0]  w_wait_nxt;
   logic             w_timeout;
   logic             w_is_halted;
   logic             w_freeze;
   logic             w_redirect;
   logic             w_pc_en;
   logic             w_if_id_en;
   logic             w_if_id_flush;
   logic             w_id_ex_en;
   logic             w_id_ex_flush;
   logic             w_ex_mem_en;
   logic             w_mem_wb_en;
   logic             w_mem_wb_flush;
   logic             w_stall_inc;
   logic             w_flush_inc;

   assign w_is_halted = (r_state == c_st_halted);
   assign w_freeze    = dmem_req & ~dmem_ready & ~w_is_halted;
   assign w_redirect  = ex_redirect & ~w_freeze & ~w_is_halted;

   // Stage control, highest priority first; flushes dominate enables downstream.
   always_comb begin
      w_pc_en        = 1'b1;
      w_if_id_en     = 1'b1;
      w_if_id_flush  = 1'b0;
      w_id_ex_en     = 1'b1;
      w_id_ex_flush  = 1'b0;
      w_ex_mem_en    = 1'b1;
      w_mem_wb_en    = 1'b1;
      w_mem_wb_flush = 1'b0;
      if (rst) begin
         w_pc_en        = 1'b0;
         w_if_id_en     = 1'b0;
         w_if_id_flush  = 1'b1;
         w_id_ex_en     = 1'b0;
         w_id_ex_flush  = 1'b1;
         w_ex_mem_en    = 1'b0;
         w_mem_wb_en    = 1'b0;
         w_mem_wb_flush = 1'b1;
      end else if (w_is_halted) begin
         w_pc_en        = 1'b0;
         w_if_id_en     = 1'b0;
         w_id_ex_en     = 1'b0;
         w_ex_mem_en    = 1'b0;
         w_mem_wb_en    = 1'b0;
      end else if (w_freeze) begin
         w_pc_en        = 1'b0;
         w_if_id_en     = 1'b0;
         w_id_ex_en     = 1'b0;
         w_ex_mem_en    = 1'b0;
         w_mem_wb_flush = 1'b1;
      end else if (ex_redirect) begin
         w_if_id_flush  = 1'b1;
         w_id_ex_flush  = 1'b1;
      end else if (hz_stall) begin
         w_pc_en        = 1'b0;
         w_if_id_en     = 1'b0;
         w_id_ex_flush  = 1'b1;
      end else if (!imem_ready) begin
         w_pc_en        = 1'b0;
         w_if_id_flush  = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait_cnt;
      w_timeout   = 1'b0;
      case (r_state)
         c_st_run: begin
            if (w_freeze) begin
               w_state_nxt = c_st_dmem_wait;
               w_wait_nxt  = '0;
            end
         end
         c_st_dmem_wait: begin
            if (w_freeze) begin
               if (r_wait_cnt == c_to_last) begin
                  w_timeout   = 1'b1;
                  w_state_nxt = c_st_halted;
               end else begin
                  w_wait_nxt  = r_wait_cnt + 1'b1;
               end
            end else begin
               w_state_nxt = c_st_run;
               w_wait_nxt  = '0;
            end
         end
         c_st_halted: w_state_nxt = c_st_halted;
         default: begin
            w_state_nxt = c_st_run;
            w_wait_nxt  = '0;
         end
      endcase
      // The retiring halt wins over any memory-wait transition.
      if (wb_halt && !w_is_halted) begin
         w_state_nxt = c_st_halted;
      end
   end

   assign w_stall_inc = ~w_is_halted & ~w_pc_en;
   assign w_flush_inc = w_redirect;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= c_st_run;
         r_wait_cnt  <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
         r_bus_err   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         if (w_timeout) begin
            r_bus_err <= 1'b1;
         end
         if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
      end
   end

   assign pc_en        = w_pc_en;
   assign if_id_en     = w_if_id_en;
   assign if_id_flush  = w_if_id_flush;
   assign id_ex_en     = w_id_ex_en;
   assign id_ex_flush  = w_id_ex_flush;
   assign ex_mem_en    = w_ex_mem_en;
   assign mem_wb_en    = w_mem_wb_en;
   assign mem_wb_flush = w_mem_wb_flush;
   assign halted       = ~rst & w_is_halted;
   assign bus_err      = r_bus_err;
   assign stall_cnt    = r_stall_cnt;
   assign flush_cnt    = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed scoreboard bench for pipeline_ctrl (default and
//               CNT_W=2 instances driven by the same stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, hz_stall, ex_redirect, imem_ready, dmem_req, dmem_ready, wb_halt;

   logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
   logic ex_mem_en, mem_wb_en, mem_wb_flush, halted, bus_err;
   logic [15:0] stall_cnt, flush_cnt;

   logic s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_flush;
   logic s_ex_mem_en, s_mem_wb_en, s_mem_wb_flush, s_halted, s_bus_err;
   logic [1:0] s_stall_cnt, s_flush_cnt;

   pipeline_ctrl #(.DMEM_TIMEOUT(16), .TO_W(5), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .hz_stall(hz_stall), .ex_redirect(ex_redirect),
      .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .wb_halt(wb_halt), .pc_en(pc_en), .if_id_en(if_id_en),
      .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
      .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
      .halted(halted), .bus_err(bus_err), .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt)
   );

   pipeline_ctrl #(.DMEM_TIMEOUT(16), .TO_W(5), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .hz_stall(hz_stall), .ex_redirect(ex_redirect),
      .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .wb_halt(wb_halt), .pc_en(s_pc_en), .if_id_en(s_if_id_en),
      .if_id_flush(s_if_id_flush), .id_ex_en(s_id_ex_en),
      .id_ex_flush(s_id_ex_flush), .ex_mem_en(s_ex_mem_en),
      .mem_wb_en(s_mem_wb_en), .mem_wb_flush(s_mem_wb_flush),
      .halted(s_halted), .bus_err(s_bus_err), .stall_cnt(s_stall_cnt),
      .flush_cnt(s_flush_cnt)
   );

   // Output vector: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
   //                 ex_mem_en, mem_wb_en, mem_wb_flush, halted}
   logic [8:0] w_outs;
   assign w_outs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                    ex_mem_en, mem_wb_en, mem_wb_flush, halted};

   localparam logic [8:0] O_DEF  = 9'b110101100;
   localparam logic [8:0] O_RST  = 9'b001010010;
   localparam logic [8:0] O_HALT = 9'b000000001;
   localparam logic [8:0] O_FRZ  = 9'b000000110;
   localparam logic [8:0] O_RED  = 9'b111111100;
   localparam logic [8:0] O_HZ   = 9'b000111100;
   localparam logic [8:0] O_FET  = 9'b011101100;

   // Input vector: {rst, wb_halt, hz_stall, ex_redirect, imem_ready, dmem_req, dmem_ready}
   localparam logic [6:0] I_RST   = 7'b1000100;
   localparam logic [6:0] I_IDLE  = 7'b0000100;
   localparam logic [6:0] I_HZ    = 7'b0010100;
   localparam logic [6:0] I_HZRD  = 7'b0011100;
   localparam logic [6:0] I_FRZRD = 7'b0001110;
   localparam logic [6:0] I_RDYRD = 7'b0001111;
   localparam logic [6:0] I_FRZ   = 7'b0000110;
   localparam logic [6:0] I_NOREQ = 7'b0000000;
   localparam logic [6:0] I_WBH   = 7'b0100100;
   localparam logic [6:0] I_FRZH  = 7'b0100110;
   localparam logic [6:0] I_T1    = 7'b0111011;
   localparam logic [6:0] I_T2    = 7'b0010101;
   localparam logic [6:0] I_T3    = 7'b0101110;

   typedef struct {
      logic [8:0]  outs;
      logic        be;
      logic [15:0] sc;
      logic [15:0] fc;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   errs   = 0;
   int   checks = 0;

   task automatic vec(input logic [6:0] iv, input logic [8:0] eo, input logic be,
                      input logic [15:0] sc, input logic [15:0] fc, input string nm);
      exp_t e;
      {rst, wb_halt, hz_stall, ex_redirect, imem_ready, dmem_req, dmem_ready} = iv;
      e.outs = eo; e.be = be; e.sc = sc; e.fc = fc; e.name = nm;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: every cycle with a pending expectation is compared mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [1:0] sat;
         e   = exp_q.pop_front();
         sat = (e.sc > 16'd3) ? 2'd3 : e.sc[1:0];
         checks++;
         if (w_outs !== e.outs) begin
            errs++;
            $display("FAIL %s outs: got %b expected %b", e.name, w_outs, e.outs);
         end
         checks++;
         if (bus_err !== e.be) begin
            errs++;
            $display("FAIL %s bus_err: got %b expected %b", e.name, bus_err, e.be);
         end
         checks++;
         if (stall_cnt !== e.sc) begin
            errs++;
            $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.sc);
         end
         checks++;
         if (flush_cnt !== e.fc) begin
            errs++;
            $display("FAIL %s flush_cnt: got %0d expected %0d", e.name, flush_cnt, e.fc);
         end
         checks++;
         if (s_stall_cnt !== sat) begin
            errs++;
            $display("FAIL %s sat_stall_cnt: got %0d expected %0d", e.name, s_stall_cnt, sat);
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      {rst, wb_halt, hz_stall, ex_redirect, imem_ready, dmem_req, dmem_ready} = I_RST;
      repeat (2) @(posedge clk);
      #1;

      vec(I_RST, O_RST, 1'b0, 16'd0, 16'd0, "reset");
      for (int i = 0; i < 5; i++) vec(I_IDLE, O_DEF, 1'b0, 16'd0, 16'd0, "idle");

      vec(I_HZ,   O_HZ,  1'b0, 16'd0, 16'd0, "hz_stall");
      vec(I_IDLE, O_DEF, 1'b0, 16'd1, 16'd0, "after_hz");

      vec(I_HZRD, O_RED, 1'b0, 16'd1, 16'd0, "redirect_over_hz");
      vec(I_IDLE, O_DEF, 1'b0, 16'd1, 16'd1, "after_redirect");

      for (int i = 0; i < 3; i++)
         vec(I_FRZRD, O_FRZ, 1'b0, 16'(1 + i), 16'd1, "freeze_with_redirect");
      vec(I_RDYRD, O_RED, 1'b0, 16'd4, 16'd1, "dmem_ready_redirect");
      vec(I_IDLE,  O_DEF, 1'b0, 16'd4, 16'd2, "after_dmem");

      vec(I_FRZ,   O_FRZ, 1'b0, 16'd4, 16'd2, "freeze_one");
      vec(I_NOREQ, O_FET, 1'b0, 16'd5, 16'd2, "wait_exit_fetch");
      vec(I_IDLE,  O_DEF, 1'b0, 16'd6, 16'd2, "after_fetch");

      vec(I_RST, O_RST, 1'b0, 16'd6, 16'd2, "reset2");
      for (int k = 0; k < 17; k++)
         vec(I_FRZ, O_FRZ, 1'b0, 16'(k), 16'd0, "timeout_freeze");
      vec(I_IDLE, O_HALT, 1'b1, 16'd17, 16'd0, "timeout_halted");
      vec(I_T1,   O_HALT, 1'b1, 16'd17, 16'd0, "halted_toggle1");
      vec(I_T2,   O_HALT, 1'b1, 16'd17, 16'd0, "halted_toggle2");
      vec(I_T3,   O_HALT, 1'b1, 16'd17, 16'd0, "halted_toggle3");
      vec(I_RST,  O_RST,  1'b1, 16'd17, 16'd0, "reset_from_halt");
      vec(I_IDLE, O_DEF,  1'b0, 16'd0,  16'd0, "run_after_halt");

      vec(I_WBH,  O_DEF,  1'b0, 16'd0, 16'd0, "wb_halt_cycle");
      vec(I_T1,   O_HALT, 1'b0, 16'd0, 16'd0, "wbh_toggle1");
      vec(I_T2,   O_HALT, 1'b0, 16'd0, 16'd0, "wbh_toggle2");
      vec(I_T3,   O_HALT, 1'b0, 16'd0, 16'd0, "wbh_toggle3");
      vec(I_RST,  O_RST,  1'b0, 16'd0, 16'd0, "reset3");

      vec(I_FRZH, O_FRZ,  1'b0, 16'd0, 16'd0, "wb_halt_in_freeze");
      vec(I_IDLE, O_HALT, 1'b0, 16'd1, 16'd0, "halt_over_dmem_wait");
      vec(I_RST,  O_RST,  1'b0, 16'd1, 16'd0, "reset4");

      for (int k = 0; k < 5; k++)
         vec(I_HZ, O_HZ, 1'b0, 16'(k), 16'd0, "sat_stall");
      vec(I_IDLE, O_DEF, 1'b0, 16'd5, 16'd0, "sat_done");

      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errs++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Combines the load-use/RAW stall request from the hazard detector, the EX-stage branch/jump redirect, instruction- and data-memory wait handshakes, and the WB-stage halt.
- Produces per-stage pipeline-register enables and flushes.
- Owns a small FSM for multi-cycle data-memory waits, a data-memory timeout, and saturating stall/flush performance counters.

Parameters:
- DMEM_TIMEOUT, 16, max consecutive DMEM_WAIT cycles before bus error (1..2^TO_W-1)
- TO_W, 5, width of the wait-cycle counter
- CNT_W, 16, width of the stall and flush performance counters

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- hz_stall  in  1  RAW stall request from hazard detection (ID sources match EX/MEM rd)
- ex_redirect  in  1  branch taken / jump resolved in EX; PC loads target this cycle
- imem_ready  in  1  instruction fetch data valid this cycle
- dmem_req  in  1  MEM stage holds a load/store this cycle
- dmem_ready  in  1  data memory completes the access this cycle
- wb_halt  in  1  ECALL/EBREAK retiring in WB
- pc_en  out  1  PC register load enable
- if_id_en  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID loads NOP (dominates if_id_en)
- id_ex_en  out  1  ID/EX register enable
- id_ex_flush  out  1  ID/EX loads bubble (dominates id_ex_en)
- ex_mem_en  out  1  EX/MEM register enable
- mem_wb_en  out  1  MEM/WB register enable
- mem_wb_flush  out  1  MEM/WB loads bubble
- halted  out  1  core stopped (state HALTED)
- bus_err  out  1  sticky, set on data-memory timeout
- stall_cnt  out  CNT_W  cycles with pc_en=0 in RUN/DMEM_WAIT, saturating
- flush_cnt  out  CNT_W  redirects taken, saturating

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at a clock edge):
  - State goes to RUN. wait_cnt, stall_cnt, flush_cnt and bus_err clear to 0.
  - While rst is high, outputs are combinationally forced: all *_en=0, all *_flush=1, halted=0.
  - Reset asserted mid-DMEM_WAIT or in HALTED returns to RUN identically.
- States: RUN, DMEM_WAIT, HALTED. Outputs are combinational from state plus inputs. Priority is highest first.
- P1, HALTED:
  - All *_en=0, all flushes=0, halted=1.
  - Inputs are ignored. Counters freeze. Exit only by rst.
- P2, memory freeze. Condition: dmem_req & !dmem_ready, in RUN or DMEM_WAIT.
  - pc_en, if_id_en, id_ex_en, ex_mem_en = 0.
  - mem_wb_flush=1 (bubble to WB), mem_wb_en=1.
  - ex_redirect and hz_stall are ignored; they stay asserted because the stages are frozen.
  - RUN goes to DMEM_WAIT.
  - In DMEM_WAIT, wait_cnt increments each freeze cycle. When wait_cnt reaches DMEM_TIMEOUT-1 and the access is still not ready: bus_err=1, state goes to HALTED at the next edge.
- DMEM_WAIT exit: on a cycle with dmem_ready=1, or with dmem_req=0, evaluate P3–P5 as in RUN. State goes to RUN and wait_cnt clears.
- P3, redirect (ex_redirect=1):
  - pc_en=1, if_id_flush=1, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1.
  - hz_stall and imem_ready are ignored, since the fetched instruction is discarded.
  - flush_cnt increments.
- P4, hazard stall (hz_stall=1):
  - pc_en=0, if_id_en=0.
  - id_ex_flush=1, ex_mem_en=1, mem_wb_en=1.
- P5, fetch wait (imem_ready=0):
  - pc_en=0, if_id_flush=1.
  - id_ex_en=1, ex_mem_en=1, mem_wb_en=1.
- Default: all *_en=1, all flushes=0.
- wb_halt=1 (any non-HALTED state): the retiring instruction completes, so mem_wb_en is as computed above. All other outputs in that cycle are also as computed. State goes to HALTED next edge. wb_halt takes precedence over the DMEM transition.
- Counters:
  - stall_cnt increments on every non-reset, non-HALTED cycle where pc_en=0.
  - Both counters saturate at 2^CNT_W-1 with no wrap.

Test Plan:
- Reset, then run 5 cycles with imem_ready=1 and no other requests -> every cycle all *_en=1, flushes=0; stall_cnt=0, flush_cnt=0.
- hz_stall=1 for 1 cycle -> that cycle pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1. Next cycle returns to the default outputs.
- ex_redirect=1 together with hz_stall=1 -> pc_en=1, if_id_flush=1, id_ex_flush=1; flush_cnt=1; stall_cnt unchanged.
- dmem_req=1, dmem_ready=0 for 3 cycles, then dmem_ready=1, with ex_redirect=1 throughout:
  - Freeze cycles: pc_en=0, mem_wb_flush=1, no flush_cnt change; state DMEM_WAIT after the first cycle.
  - Ready cycle: redirect applied; flush_cnt=1; stall_cnt=3; state RUN.
- DMEM_TIMEOUT=16, with dmem_req=1 and dmem_ready=0 held -> bus_err=1 and halted=1 after 17 edges. Outputs stay frozen until rst=1, which clears bus_err and returns to RUN.
- wb_halt=1 -> next cycle halted=1, all enables 0. Toggling every input has no effect. Force stall_cnt to its maximum via CNT_W=2 and 5 stall cycles -> stall_cnt stays at 3.
